rle_rx_frame_ctrl: RTL and testbench

//  Frames the 16-bit word stream from the UART receiver (done pulse + dout) into length-delimited packets for the RLE core.

---
 rtl/rle_rx_frame_ctrl.sv | 152 +++++++++++++++
 tb/tb_rle_rx_frame_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rle_rx_frame_ctrl.sv
// Frames UART words into length-delimited packets behind a DEPTH-word FIFO; push-to-out_valid is 1 cycle.
// Downstream stalls are absorbed by the FIFO; a push into a full FIFO aborts the frame and clears it.
module rle_rx_frame_ctrl #(
  parameter int          DEPTH        = 16,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int          TIMEOUT_CLKS = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_done,
  input  logic [15:0] rx_data,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [7:0]  frame_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CLKS);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {S_HDR, S_DATA, S_DISC} state_t;

  typedef struct packed {
    logic        last;
    logic [15:0] dat;
  } entry_t;

  state_t        state_q, state_d;
  logic [7:0]    rem_q, rem_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic          err_q, err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          frame_done_q, frame_done_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;

  logic   empty, full, pop_req, pop, push, clr;
  entry_t head;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  assign out_valid  = !empty;
  assign out_data   = out_valid ? head.dat : 16'h0000;
  assign out_last   = out_valid & head.last;
  assign busy       = (state_q != S_HDR) || !empty;
  assign frame_done = frame_done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign frame_cnt  = frame_cnt_q;
  assign pop_req    = out_valid & out_ready;

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    timer_d    = timer_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    push       = 1'b0;
    clr        = 1'b0;
    mem_d      = mem_q;

    case (state_q)
      S_HDR: begin
        if (rx_done) begin
          if (rx_data[15:8] == SYNC_BYTE && rx_data[7:0] != 8'd0) begin
            rem_d   = rx_data[7:0];
            timer_d = '0;
            state_d = S_DATA;
          end else begin
            err_d      = 1'b1;
            err_code_d = 2'b01;
          end
        end
      end
      S_DATA, S_DISC: begin
        if (rx_done) begin
          timer_d = '0;
          rem_d   = rem_q - 8'd1;
          if (rem_q == 8'd1) state_d = S_HDR;
          if (state_q == S_DATA) begin
            // A pop in the same cycle frees the slot being written.
            if (!full || pop_req) begin
              push = 1'b1;
            end else begin
              err_d      = 1'b1;
              err_code_d = 2'b10;
              clr        = 1'b1;
              if (rem_q != 8'd1) state_d = S_DISC;
            end
          end
        end else if (timer_q == TMAX) begin
          err_d      = 1'b1;
          err_code_d = 2'b11;
          clr        = 1'b1;
          timer_d    = '0;
          state_d    = S_HDR;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = S_HDR;
    endcase

    pop = pop_req & !clr;

    if (push) mem_d[wr_ptr_q[AW-1:0]] = '{last: (rem_q == 8'd1), dat: rx_data};

    wr_ptr_d = clr ? '0 : wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = clr ? '0 : rd_ptr_q + {{AW{1'b0}}, pop};

    frame_done_d = pop & head.last;
    frame_cnt_d  = frame_cnt_q + {7'd0, frame_done_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_HDR;
      rem_q        <= '0;
      timer_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      err_q        <= 1'b0;
      err_code_q   <= 2'b00;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      timer_q      <= timer_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      mem_q        <= mem_d;
    end
  end

endmodule

// File: tb/tb_rle_rx_frame_ctrl.sv
// Directed bench for rle_rx_frame_ctrl: cycle table for clean frames and bad headers,
// hand sequences for overflow, timeout and mid-frame reset.
module tb_rle_rx_frame_ctrl;

  localparam int TIMEOUT = 20000;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_done;
  logic [15:0] rx_data;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_ready;
  logic        busy;
  logic        frame_done;
  logic        err;
  logic [1:0]  err_code;
  logic [7:0]  frame_cnt;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  rle_rx_frame_ctrl #(
    .DEPTH(16),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CLKS(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_done(rx_done),
    .rx_data(rx_data),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_last(out_last),
    .out_ready(out_ready),
    .busy(busy),
    .frame_done(frame_done),
    .err(err),
    .err_code(err_code),
    .frame_cnt(frame_cnt)
  );

  typedef struct {
    logic        done;
    logic [15:0] dat;
    logic        rdy;
    logic        vld;
    logic [15:0] odat;
    logic        last;
    logic        err;
    logic [1:0]  code;
    logic        fd;
    logic [7:0]  cnt;
    logic        busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic d, input logic [15:0] w, input logic r,
                             input logic ev, input logic [15:0] ed, input logic el,
                             input logic ee, input logic [1:0] ec, input logic ef,
                             input logic [7:0] en, input logic eb);
    vec_t x;
    x.done = d;  x.dat = w;   x.rdy = r;
    x.vld = ev;  x.odat = ed; x.last = el;
    x.err = ee;  x.code = ec; x.fd = ef;
    x.cnt = en;  x.busy = eb;
    return x;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then sample 1 time unit later.
  task automatic step(input logic d, input logic [15:0] w, input logic r);
    rx_done   = d;
    rx_data   = w;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_valid"}, 0, 32'(out_valid), 32'd0);
    chk({name, "_data"},  0, 32'(out_data),  32'd0);
    chk({name, "_last"},  0, 32'(out_last),  32'd0);
    chk({name, "_err"},   0, 32'(err),       32'd0);
    chk({name, "_code"},  0, 32'(err_code),  32'd0);
    chk({name, "_fd"},    0, 32'(frame_done), 32'd0);
    chk({name, "_cnt"},   0, 32'(frame_cnt), 32'd0);
    chk({name, "_busy"},  0, 32'(busy),      32'd0);
  endtask

  initial begin
    int seen;
    logic v_at, b_at;
    logic [1:0] c_at;

    // T1: clean 3-word frame with out_ready=1
    tbl.push_back(v(1, 16'hA503, 1,  0, 16'h0000, 0, 0, 2'd0, 0, 8'd0, 1));
    tbl.push_back(v(1, 16'h0011, 1,  1, 16'h0011, 0, 0, 2'd0, 0, 8'd0, 1));
    tbl.push_back(v(1, 16'h0022, 1,  1, 16'h0022, 0, 0, 2'd0, 0, 8'd0, 1));
    tbl.push_back(v(1, 16'h0033, 1,  1, 16'h0033, 1, 0, 2'd0, 0, 8'd0, 1));
    tbl.push_back(v(0, 16'h0000, 1,  0, 16'h0000, 0, 0, 2'd0, 1, 8'd1, 0));
    tbl.push_back(v(0, 16'h0000, 1,  0, 16'h0000, 0, 0, 2'd0, 0, 8'd1, 0));
    // T2: wrong sync byte, then zero length
    tbl.push_back(v(1, 16'h1203, 1,  0, 16'h0000, 0, 1, 2'd1, 0, 8'd1, 0));
    tbl.push_back(v(1, 16'hA500, 1,  0, 16'h0000, 0, 1, 2'd1, 0, 8'd1, 0));
    tbl.push_back(v(0, 16'h0000, 1,  0, 16'h0000, 0, 0, 2'd1, 0, 8'd1, 0));
    // T5: two back-to-back 2-word frames, out_ready toggling
    tbl.push_back(v(1, 16'hA502, 1,  0, 16'h0000, 0, 0, 2'd1, 0, 8'd1, 1));
    tbl.push_back(v(1, 16'h0001, 0,  1, 16'h0001, 0, 0, 2'd1, 0, 8'd1, 1));
    tbl.push_back(v(1, 16'h0002, 1,  1, 16'h0002, 1, 0, 2'd1, 0, 8'd1, 1));
    tbl.push_back(v(1, 16'hA502, 0,  1, 16'h0002, 1, 0, 2'd1, 0, 8'd1, 1));
    tbl.push_back(v(1, 16'h0003, 1,  1, 16'h0003, 0, 0, 2'd1, 1, 8'd2, 1));
    tbl.push_back(v(1, 16'h0004, 0,  1, 16'h0003, 0, 0, 2'd1, 0, 8'd2, 1));
    tbl.push_back(v(0, 16'h0000, 1,  1, 16'h0004, 1, 0, 2'd1, 0, 8'd2, 1));
    tbl.push_back(v(0, 16'h0000, 0,  1, 16'h0004, 1, 0, 2'd1, 0, 8'd2, 1));
    tbl.push_back(v(0, 16'h0000, 1,  0, 16'h0000, 0, 0, 2'd1, 1, 8'd3, 0));
    tbl.push_back(v(0, 16'h0000, 0,  0, 16'h0000, 0, 0, 2'd1, 0, 8'd3, 0));

    rst = 1'b1;
    step(0, 16'h0000, 0);
    step(0, 16'h0000, 0);
    chk_reset_outputs("reset");
    rst = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].done, tbl[i].dat, tbl[i].rdy);
      chk("tbl_valid", i, 32'(out_valid),  32'(tbl[i].vld));
      chk("tbl_data",  i, 32'(out_data),   32'(tbl[i].odat));
      chk("tbl_last",  i, 32'(out_last),   32'(tbl[i].last));
      chk("tbl_err",   i, 32'(err),        32'(tbl[i].err));
      chk("tbl_code",  i, 32'(err_code),   32'(tbl[i].code));
      chk("tbl_fd",    i, 32'(frame_done), 32'(tbl[i].fd));
      chk("tbl_cnt",   i, 32'(frame_cnt),  32'(tbl[i].cnt));
      chk("tbl_busy",  i, 32'(busy),       32'(tbl[i].busy));
    end

    // T3: 20-word frame into a stalled 16-deep FIFO
    step(1, 16'hA514, 0);
    for (int i = 0; i < 16; i++) step(1, 16'h0100 + 16'(i), 0);
    chk("ovf_full_valid", 0, 32'(out_valid), 32'd1);
    chk("ovf_full_head",  0, 32'(out_data),  32'h0100);
    chk("ovf_full_err",   0, 32'(err),       32'd0);
    step(1, 16'h0110, 0);
    chk("ovf_err",   0, 32'(err),       32'd1);
    chk("ovf_code",  0, 32'(err_code),  32'd2);
    chk("ovf_valid", 0, 32'(out_valid), 32'd0);
    step(1, 16'h0111, 0);
    step(1, 16'h0112, 0);
    chk("disc_busy", 0, 32'(busy),      32'd1);
    chk("disc_err",  0, 32'(err),       32'd0);
    step(1, 16'h0113, 0);
    chk("disc_done_busy",  0, 32'(busy),      32'd0);
    chk("disc_done_valid", 0, 32'(out_valid), 32'd0);
    step(1, 16'hA501, 1);
    step(1, 16'hBEEF, 1);
    chk("resync_valid", 0, 32'(out_valid), 32'd1);
    chk("resync_data",  0, 32'(out_data),  32'hBEEF);
    chk("resync_last",  0, 32'(out_last),  32'd1);
    step(0, 16'h0000, 1);
    chk("resync_fd",  0, 32'(frame_done), 32'd1);
    chk("resync_cnt", 0, 32'(frame_cnt),  32'd4);

    // T4: inter-word timeout with two words parked in the FIFO
    step(1, 16'hA504, 0);
    step(1, 16'h0001, 0);
    step(1, 16'h0002, 0);
    chk("to_pre_valid", 0, 32'(out_valid), 32'd1);
    seen = 0; v_at = 1'b1; b_at = 1'b1; c_at = 2'd0;
    for (int n = 1; n <= TIMEOUT + 4; n++) begin
      step(0, 16'h0000, 0);
      if (seen == 0 && err === 1'b1) begin
        seen = n;
        v_at = out_valid;
        b_at = busy;
        c_at = err_code;
      end
    end
    chk("to_latency", 0, 32'(seen), 32'(TIMEOUT));
    chk("to_code",    0, 32'(c_at), 32'd3);
    chk("to_valid",   0, 32'(v_at), 32'd0);
    chk("to_busy",    0, 32'(b_at), 32'd0);

    // T6: reset with three words buffered, then a clean frame
    step(1, 16'hA505, 0);
    step(1, 16'h0A01, 0);
    step(1, 16'h0A02, 0);
    step(1, 16'h0A03, 0);
    chk("rst_pre_valid", 0, 32'(out_valid), 32'd1);
    chk("rst_pre_head",  0, 32'(out_data),  32'h0A01);
    rst = 1'b1;
    step(0, 16'h0000, 0);
    chk_reset_outputs("midrst");
    rst = 1'b0;
    step(1, 16'hA501, 1);
    step(1, 16'h1234, 1);
    chk("post_rst_valid", 0, 32'(out_valid), 32'd1);
    chk("post_rst_data",  0, 32'(out_data),  32'h1234);
    chk("post_rst_last",  0, 32'(out_last),  32'd1);
    step(0, 16'h0000, 1);
    chk("post_rst_fd",    0, 32'(frame_done), 32'd1);
    chk("post_rst_cnt",   0, 32'(frame_cnt),  32'd1);
    chk("post_rst_valid2", 0, 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
